alarm_bank: RTL

ALARM_BANK -- requirements
Module: alarm_bank

---
 rtl/alarm_bank_pkg.sv | 46 ++++
 rtl/alarm_slot.sv | 35 +++
 rtl/alarm_bank.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alarm_bank_pkg.sv
// Shared types, BCD limits and helpers for the alarm bank.
//   state_e     : ring controller states
//   bcd_time_t  : four-digit BCD time hh:mm, most significant digit first
//   time_valid  : true when a BCD time lies inside 00:00-23:59
//   sat_dec     : minute counter decrement that stops at zero
package alarm_bank_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CNT_W   = 6;

  // Largest legal value of each BCD digit position
  localparam logic [DIGIT_W-1:0] MAX_MS_HR     = 4'd2;
  localparam logic [DIGIT_W-1:0] MAX_LS_HR     = 4'd9;
  localparam logic [DIGIT_W-1:0] MAX_LS_HR_20S = 4'd3;
  localparam logic [DIGIT_W-1:0] MAX_MS_MIN    = 4'd5;
  localparam logic [DIGIT_W-1:0] MAX_LS_MIN    = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] ms_hr;
    logic [DIGIT_W-1:0] ls_hr;
    logic [DIGIT_W-1:0] ms_min;
    logic [DIGIT_W-1:0] ls_min;
  } bcd_time_t;

  // Hours 20-23 restrict the units digit; 00-19 allow any decimal digit
  function automatic logic time_valid(input bcd_time_t t);
    logic hr_ok;
    if (t.ms_hr == MAX_MS_HR) begin
      hr_ok = (t.ls_hr <= MAX_LS_HR_20S);
    end else begin
      hr_ok = (t.ms_hr < MAX_MS_HR) && (t.ls_hr <= MAX_LS_HR);
    end
    return hr_ok && (t.ms_min <= MAX_MS_MIN) && (t.ls_min <= MAX_LS_MIN);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: stored BCD time plus enable, with a combinational match.
//   clock, reset : clock and asynchronous active-high reset
//   wr_en        : load wr_time / wr_enable on this edge
//   cur_time     : current wall-clock time
//   alarm_time   : stored time (registered)
//   enabled      : stored enable (registered)
//   match_c      : slot enabled and stored time equals cur_time
module alarm_slot
  import alarm_bank_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      wr_en,
  input  bcd_time_t wr_time,
  input  logic      wr_enable,
  input  bcd_time_t cur_time,
  output bcd_time_t alarm_time,
  output logic      enabled,
  output logic      match_c
);

  // Time and enable storage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alarm_time <= '0;
      enabled    <= 1'b0;
    end else if (wr_en) begin
      alarm_time <= wr_time;
      enabled    <= wr_enable;
    end
  end

  assign match_c = enabled && (alarm_time == cur_time);

endmodule

// File: rtl/alarm_bank.sv
// Bank of alarm slots with a shared ring / snooze / auto-stop controller.
//   clock, reset            : clock and asynchronous active-high reset
//   load_new_a, wr_slot,
//   new_alarm_time_*,
//   new_enable              : slot write port (invalid writes pulse load_error)
//   rd_slot, alarm_time_*,
//   alarm_enabled           : combinational read port
//   cur_*, minute_tick      : current time and start-of-minute pulse
//   snooze, stop            : user pulses
//   alarm_ringing           : registered, high while ringing
//   ringing_slot            : slot that triggered the current ring
//   load_error              : one-cycle pulse after a rejected write
module alarm_bank
  import alarm_bank_pkg::*;
#(
  parameter int unsigned NUM_ALARMS       = 4,
  parameter int unsigned SNOOZE_MIN       = 9,
  parameter int unsigned RING_TIMEOUT_MIN = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_new_a,
  input  logic [$clog2(NUM_ALARMS)-1:0] wr_slot,
  input  logic [3:0]                    new_alarm_time_ms_hr,
  input  logic [3:0]                    new_alarm_time_ls_hr,
  input  logic [3:0]                    new_alarm_time_ms_min,
  input  logic [3:0]                    new_alarm_time_ls_min,
  input  logic                          new_enable,
  input  logic [$clog2(NUM_ALARMS)-1:0] rd_slot,
  input  logic [3:0]                    cur_ms_hr,
  input  logic [3:0]                    cur_ls_hr,
  input  logic [3:0]                    cur_ms_min,
  input  logic [3:0]                    cur_ls_min,
  input  logic                          minute_tick,
  input  logic                          snooze,
  input  logic                          stop,
  output logic [3:0]                    alarm_time_ms_hr,
  output logic [3:0]                    alarm_time_ls_hr,
  output logic [3:0]                    alarm_time_ms_min,
  output logic [3:0]                    alarm_time_ls_min,
  output logic                          alarm_enabled,
  output logic                          alarm_ringing,
  output logic [$clog2(NUM_ALARMS)-1:0] ringing_slot,
  output logic                          load_error
);

  localparam int unsigned SW = $clog2(NUM_ALARMS);

  bcd_time_t wr_time;
  bcd_time_t cur_time;
  bcd_time_t rd_time;
  logic      rd_enabled;
  logic      write_ok;
  logic      kill_ring;

  bcd_time_t             slot_time [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] slot_en;
  logic [NUM_ALARMS-1:0] slot_match;
  logic [NUM_ALARMS-1:0] slot_we;

  logic          hit;
  logic [SW-1:0] hit_idx;

  state_e        state_q, state_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [CNT_W-1:0] snooze_q, snooze_d;
  logic [SW-1:0] ringing_slot_d;
  logic          alarm_ringing_d;
  logic          load_error_d;

  assign wr_time  = '{ms_hr: new_alarm_time_ms_hr, ls_hr: new_alarm_time_ls_hr,
                      ms_min: new_alarm_time_ms_min, ls_min: new_alarm_time_ls_min};
  assign cur_time = '{ms_hr: cur_ms_hr, ls_hr: cur_ls_hr,
                      ms_min: cur_ms_min, ls_min: cur_ls_min};

  // Slot index is widened so non-power-of-two banks reject the unused codes
  assign write_ok = time_valid(wr_time) && (5'(wr_slot) < 5'(NUM_ALARMS));

  // Disabling the slot that is ringing or snoozing cancels the alarm
  assign kill_ring = load_new_a && write_ok && !new_enable && (wr_slot == ringing_slot);

  // Slot storage
  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
    assign slot_we[g] = load_new_a && write_ok && (wr_slot == SW'(g));

    alarm_slot u_slot (
      .clock      (clock),
      .reset      (reset),
      .wr_en      (slot_we[g]),
      .wr_time    (wr_time),
      .wr_enable  (new_enable),
      .cur_time   (cur_time),
      .alarm_time (slot_time[g]),
      .enabled    (slot_en[g]),
      .match_c    (slot_match[g])
    );
  end

  // Read mux
  always_comb begin
    rd_time    = '0;
    rd_enabled = 1'b0;
    for (int i = 0; i < int'(NUM_ALARMS); i++) begin
      if (rd_slot == SW'(i)) begin
        rd_time    = slot_time[i];
        rd_enabled = slot_en[i];
      end
    end
  end

  assign alarm_time_ms_hr  = rd_time.ms_hr;
  assign alarm_time_ls_hr  = rd_time.ls_hr;
  assign alarm_time_ms_min = rd_time.ms_min;
  assign alarm_time_ls_min = rd_time.ls_min;
  assign alarm_enabled     = rd_enabled;

  // Lowest-index matching slot
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < int'(NUM_ALARMS); i++) begin
      if (!hit && slot_match[i]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  // Controller state and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      timeout_q     <= '0;
      snooze_q      <= '0;
      ringing_slot  <= '0;
      alarm_ringing <= 1'b0;
      load_error    <= 1'b0;
    end else begin
      state_q       <= state_d;
      timeout_q     <= timeout_d;
      snooze_q      <= snooze_d;
      ringing_slot  <= ringing_slot_d;
      alarm_ringing <= alarm_ringing_d;
      load_error    <= load_error_d;
    end
  end

  // Next state: stop and enable-clear beat snooze, snooze beats the timeout tick
  always_comb begin
    state_d         = state_q;
    timeout_d       = timeout_q;
    snooze_d        = snooze_q;
    ringing_slot_d  = ringing_slot;
    alarm_ringing_d = 1'b0;
    load_error_d    = load_new_a && !write_ok;

    unique case (state_q)
      ST_IDLE: begin
        if (minute_tick && hit) begin
          state_d        = ST_RING;
          ringing_slot_d = hit_idx;
          timeout_d      = CNT_W'(RING_TIMEOUT_MIN);
        end
      end
      ST_RING: begin
        if (stop || kill_ring) begin
          state_d = ST_IDLE;
        end else if (snooze) begin
          state_d  = ST_SNOOZE;
          snooze_d = CNT_W'(SNOOZE_MIN);
        end else if (minute_tick) begin
          timeout_d = sat_dec(timeout_q);
          if (timeout_d == '0) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SNOOZE: begin
        if (stop || kill_ring) begin
          state_d = ST_IDLE;
        end else if (minute_tick) begin
          snooze_d = sat_dec(snooze_q);
          if (snooze_d == '0) begin
            state_d   = ST_RING;
            timeout_d = CNT_W'(RING_TIMEOUT_MIN);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    alarm_ringing_d = (state_d == ST_RING);
  end

endmodule
